engine_key_generator: RTL and testbench
=======================================

# engine_key_generator

Expands a 128-bit AES cipher key into the eleven AES-128 round keys, computing one round key per clock cycle. It sits directly upstream of engine_round_transformer, driving its round0_key..round10_key inputs and its transformer_start. After one start pulse, it holds the key schedule stable until the transformer reports transformer_done. Start requests arrive from input_interface.

## Interface
Parameters: none. Key size is fixed at AES-128.

- clk  input  1  single system clock; all state updates on the rising edge
- rst_  input  1  reset, synchronous, active-high
- key_start  input  1  single-cycle request to expand cipher_key; accepted only in IDLE
- cipher_key  input  128  cipher key; sampled only in the accept cycle; byte 0 is bits [127:120]
- transformer_done  input  1  completion pulse from engine_round_transformer
- round0_key .. round10_key  output  128 each  registered key schedule; round0_key equals cipher_key
- transformer_start  output  1  one-cycle pulse; all round keys are valid and stable
- key_busy  output  1  high from accept until the return to IDLE; input_interface must not issue key_start while it is high

## Operation
- State machine states: IDLE, EXPAND, START, WAIT.
- IDLE
  - With key_start=1: latch cipher_key into round0_key, set rnd=1, go to EXPAND.
  - With key_start=0: hold.
- EXPAND, once per cycle:
  - Compute round[rnd] from round[rnd-1]:
    - t = SubWord(RotWord(w3)) ^ {rcon[rnd], 24'h0}
    - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
    - w0 is bits [127:96] of round[rnd-1].
  - Register the result into round[rnd] and increment rnd.
  - When rnd=10 is written, go to START.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. rnd is a 4-bit counter and never exceeds 10.
- START: assert transformer_start for exactly one cycle, then go to WAIT.
- WAIT: hold all keys. On transformer_done=1, go to IDLE.
- key_start outside IDLE is ignored. No queuing and no error flag.
- transformer_done outside WAIT is ignored.
- Round keys not yet rewritten during EXPAND keep their previous values. Consumers must only use the keys after transformer_start.
- Reset at any point:
  - All round keys = 0, rnd = 0, state = IDLE.
  - transformer_start = 0, key_busy = 0.
  - Any in-flight expansion is abandoned, and no transformer_start is emitted for it.

## Timing
- Accept at cycle T (IDLE, key_start=1):
  - round0_key is valid from T+1.
  - round k is valid from T+1+k.
  - round10_key is valid from T+11.
- transformer_start is high in cycle T+11 only, giving a start-to-start latency of 11 cycles.
- key_busy is high from T+1 through the cycle in which WAIT sees transformer_done. It is low the following cycle, which is in IDLE.
- A key_start coinciding with the transformer_done cycle is ignored. The earliest accept is the next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values: every output is 0.

## Structure
- Shared package aes_pkg holds:
  - the state enum (IDLE, EXPAND, START, WAIT)
  - the RCON constant array
  - the AES S-box constant table, which is reused by the SubBytes stage
- One sub-module, aes_sbox: combinational 8-bit lookup.
  - Four instances implement SubWord.
  - engine_round_transformer reuses the same module.
- Keep the round keys as an internal 11-entry array, unpacked to the eleven output ports.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start at T:
  - round1_key = a0fafe1788542cb123a339392a6c7605
  - round10_key = d014f9a8c9ee2589e13f0cc8b6630ca6
  - transformer_start high at T+11 only
- All-zero key:
  - round1_key = 62636363626363636263636362636363
  - round10_key = b4ef5bcb3e92e21123e951cf6f8f188e
- key_start pulsed at T+3 and T+12 with a different key:
  - both are ignored and the schedule is unchanged
  - key_busy stays high until transformer_done is applied, then drops one cycle later
- rst_ asserted at T+5 mid-expansion:
  - next cycle, all round keys = 0 and key_busy = 0
  - no transformer_start pulse follows
  - a fresh start after reset produces the correct A.1 schedule
- transformer_done pulsed in IDLE and in EXPAND: no effect. Then back-to-back runs with transformer_done and key_start in the same cycle:
  - that key_start is ignored
  - a key_start one cycle later is accepted, and its schedule is correct at +11

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key-expansion FSM states, round constants and
// the forward S-box table used by both the key schedule and SubBytes.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } key_state_e;

  // Entry 0 is unused; round r uses RCON[r] for r = 1..10.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/engine_key_generator.sv
// AES-128 key expansion, one round key per cycle, holding the full schedule
// stable for the round transformer until it reports completion.
module engine_key_generator
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_,
  input  logic         key_start,
  input  logic [127:0] cipher_key,
  input  logic         transformer_done,
  output logic [127:0] round0_key,
  output logic [127:0] round1_key,
  output logic [127:0] round2_key,
  output logic [127:0] round3_key,
  output logic [127:0] round4_key,
  output logic [127:0] round5_key,
  output logic [127:0] round6_key,
  output logic [127:0] round7_key,
  output logic [127:0] round8_key,
  output logic [127:0] round9_key,
  output logic [127:0] round10_key,
  output logic         transformer_start,
  output logic         key_busy
);

  key_state_e   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] round_keys_q [11];
  logic [127:0] round_keys_d [11];
  logic         start_q, start_d;
  logic         busy_q, busy_d;

  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;
  logic [127:0] next_key;

  always_comb begin
    prev_key = round_keys_q[0];
    for (int i = 1; i < 11; i++) begin
      if (rnd_q == 4'(i)) prev_key = round_keys_q[i-1];
    end
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*g +: 8]),
      .out_byte (sub_word[8*g +: 8])
    );
  end

  // Each word chains off the freshly computed word to its left.
  assign temp_word       = sub_word ^ {RCON[rnd_q], 24'h0};
  assign next_key[127:96] = prev_key[127:96] ^ temp_word;
  assign next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    round_keys_d = round_keys_q;
    start_d      = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (key_start) begin
          round_keys_d[0] = cipher_key;
          rnd_d           = 4'd1;
          busy_d          = 1'b1;
          state_d         = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i < 11; i++) begin
          if (rnd_q == 4'(i)) round_keys_d[i] = next_key;
        end
        if (rnd_q == 4'd10) begin
          start_d = 1'b1;
          state_d = START;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (transformer_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 11; i++) round_keys_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      round_keys_q <= round_keys_d;
    end
  end

  assign round0_key        = round_keys_q[0];
  assign round1_key        = round_keys_q[1];
  assign round2_key        = round_keys_q[2];
  assign round3_key        = round_keys_q[3];
  assign round4_key        = round_keys_q[4];
  assign round5_key        = round_keys_q[5];
  assign round6_key        = round_keys_q[6];
  assign round7_key        = round_keys_q[7];
  assign round8_key        = round_keys_q[8];
  assign round9_key        = round_keys_q[9];
  assign round10_key       = round_keys_q[10];
  assign transformer_start = start_q;
  assign key_busy          = busy_q;

endmodule

// File: tb/tb_engine_key_generator.sv
// Directed bench for engine_key_generator using FIPS-197 A.1 and all-zero key vectors.
module tb_engine_key_generator;

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_;
  logic         key_start;
  logic [127:0] cipher_key;
  logic         transformer_done;
  logic [127:0] round0_key, round1_key, round2_key, round3_key, round4_key, round5_key;
  logic [127:0] round6_key, round7_key, round8_key, round9_key, round10_key;
  logic         transformer_start;
  logic         key_busy;

  int errors = 0;
  int checks = 0;

  engine_key_generator dut (
    .clk               (clk),
    .rst_              (rst_),
    .key_start         (key_start),
    .cipher_key        (cipher_key),
    .transformer_done  (transformer_done),
    .round0_key        (round0_key),
    .round1_key        (round1_key),
    .round2_key        (round2_key),
    .round3_key        (round3_key),
    .round4_key        (round4_key),
    .round5_key        (round5_key),
    .round6_key        (round6_key),
    .round7_key        (round7_key),
    .round8_key        (round8_key),
    .round9_key        (round9_key),
    .round10_key       (round10_key),
    .transformer_start (transformer_start),
    .key_busy          (key_busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs and samples both live here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; key_start = 1'b0; transformer_done = 1'b0; cipher_key = '0;
    tick(); tick();
    checks++; if (round0_key !== '0) begin errors++; $display("[TB] FAIL reset_round0 got=%h exp=0", round0_key); end
    checks++; if (round10_key !== '0) begin errors++; $display("[TB] FAIL reset_round10 got=%h exp=0", round10_key); end
    checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got=%b exp=0", transformer_start); end
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", key_busy); end
    rst_ = 1'b0;
    tick();
  endtask

  task automatic test_a1_schedule();
    cipher_key = A1_KEY; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    checks++; if (round0_key !== A1_KEY) begin errors++; $display("[TB] FAIL a1_round0 got=%h exp=%h", round0_key, A1_KEY); end
    checks++; if (key_busy !== 1'b1) begin errors++; $display("[TB] FAIL a1_busy_t1 got=%b exp=1", key_busy); end
    checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL a1_start_t1 got=%b exp=0", transformer_start); end
    for (int k = 2; k <= 10; k++) begin
      tick();
      checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL a1_start_early t+%0d got=%b exp=0", k, transformer_start); end
    end
    tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL a1_start_t11 got=%b exp=1", transformer_start); end
    checks++; if (round1_key !== A1_R1) begin errors++; $display("[TB] FAIL a1_round1 got=%h exp=%h", round1_key, A1_R1); end
    checks++; if (round2_key !== A1_R2) begin errors++; $display("[TB] FAIL a1_round2 got=%h exp=%h", round2_key, A1_R2); end
    checks++; if (round10_key !== A1_R10) begin errors++; $display("[TB] FAIL a1_round10 got=%h exp=%h", round10_key, A1_R10); end
    tick();
    checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL a1_start_t12 got=%b exp=0", transformer_start); end
    checks++; if (key_busy !== 1'b1) begin errors++; $display("[TB] FAIL a1_busy_wait got=%b exp=1", key_busy); end
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL a1_busy_after_done got=%b exp=0", key_busy); end
    checks++; if (round10_key !== A1_R10) begin errors++; $display("[TB] FAIL a1_round10_hold got=%h exp=%h", round10_key, A1_R10); end
  endtask

  task automatic test_zero_key();
    cipher_key = '0; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int k = 2; k <= 11; k++) tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL zero_start_t11 got=%b exp=1", transformer_start); end
    checks++; if (round1_key !== Z_R1) begin errors++; $display("[TB] FAIL zero_round1 got=%h exp=%h", round1_key, Z_R1); end
    checks++; if (round10_key !== Z_R10) begin errors++; $display("[TB] FAIL zero_round10 got=%h exp=%h", round10_key, Z_R10); end
    tick();
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
  endtask

  task automatic test_ignore_start();
    cipher_key = A1_KEY; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    tick(); tick();
    cipher_key = '0; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int k = 5; k <= 11; k++) tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL ign_start_t11 got=%b exp=1", transformer_start); end
    checks++; if (round1_key !== A1_R1) begin errors++; $display("[TB] FAIL ign_round1 got=%h exp=%h", round1_key, A1_R1); end
    tick();
    cipher_key = '0; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    checks++; if (round0_key !== A1_KEY) begin errors++; $display("[TB] FAIL ign_round0 got=%h exp=%h", round0_key, A1_KEY); end
    checks++; if (round10_key !== A1_R10) begin errors++; $display("[TB] FAIL ign_round10 got=%h exp=%h", round10_key, A1_R10); end
    checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL ign_no_restart got=%b exp=0", transformer_start); end
    tick(); tick(); tick();
    checks++; if (key_busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy_hold got=%b exp=1", key_busy); end
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy_drop got=%b exp=0", key_busy); end
  endtask

  task automatic test_reset_mid_expansion();
    int start_seen;
    cipher_key = A1_KEY; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    checks++; if (round0_key !== '0) begin errors++; $display("[TB] FAIL rstmid_round0 got=%h exp=0", round0_key); end
    checks++; if (round1_key !== '0) begin errors++; $display("[TB] FAIL rstmid_round1 got=%h exp=0", round1_key); end
    checks++; if (round3_key !== '0) begin errors++; $display("[TB] FAIL rstmid_round3 got=%h exp=0", round3_key); end
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", key_busy); end
    start_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (transformer_start === 1'b1) start_seen++;
      tick();
    end
    checks++; if (start_seen != 0) begin errors++; $display("[TB] FAIL rstmid_no_start got=%0d pulses exp=0", start_seen); end
    cipher_key = A1_KEY; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int k = 2; k <= 11; k++) tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_fresh_start got=%b exp=1", transformer_start); end
    checks++; if (round1_key !== A1_R1) begin errors++; $display("[TB] FAIL rstmid_fresh_round1 got=%h exp=%h", round1_key, A1_R1); end
    checks++; if (round10_key !== A1_R10) begin errors++; $display("[TB] FAIL rstmid_fresh_round10 got=%h exp=%h", round10_key, A1_R10); end
    tick();
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_done_busy got=%b exp=0", key_busy); end
    checks++; if (transformer_start !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_done_start got=%b exp=0", transformer_start); end
    cipher_key = '0; key_start = 1'b1;
    tick();
    key_start = 1'b0;
    tick();
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    for (int k = 4; k <= 11; k++) tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL b2b_expand_done_start got=%b exp=1", transformer_start); end
    checks++; if (round10_key !== Z_R10) begin errors++; $display("[TB] FAIL b2b_zero_round10 got=%h exp=%h", round10_key, Z_R10); end
    tick();
    checks++; if (key_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wait_busy got=%b exp=1", key_busy); end
    transformer_done = 1'b1; key_start = 1'b1; cipher_key = A1_KEY;
    tick();
    transformer_done = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_coincident_busy got=%b exp=0", key_busy); end
    checks++; if (round0_key !== '0) begin errors++; $display("[TB] FAIL b2b_coincident_round0 got=%h exp=0", round0_key); end
    tick();
    key_start = 1'b0;
    checks++; if (round0_key !== A1_KEY) begin errors++; $display("[TB] FAIL b2b_accept_round0 got=%h exp=%h", round0_key, A1_KEY); end
    checks++; if (key_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_busy got=%b exp=1", key_busy); end
    for (int k = 2; k <= 11; k++) tick();
    checks++; if (transformer_start !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_start got=%b exp=1", transformer_start); end
    checks++; if (round1_key !== A1_R1) begin errors++; $display("[TB] FAIL b2b_round1 got=%h exp=%h", round1_key, A1_R1); end
    checks++; if (round10_key !== A1_R10) begin errors++; $display("[TB] FAIL b2b_round10 got=%h exp=%h", round10_key, A1_R10); end
    tick();
    transformer_done = 1'b1;
    tick();
    transformer_done = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_busy got=%b exp=0", key_busy); end
  endtask

  initial begin
    test_reset();
    test_a1_schedule();
    test_zero_key();
    test_ignore_start();
    test_reset_mid_expansion();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
